// File: rtl/cordic_link_pkg.sv
// Shared definitions for the host side of the CORDIC byte link.
//   state_t  : link FSM states
//   TX_BYTES : bytes per request frame (x lo/hi, y lo/hi)
//   RX_BYTES : bytes per result frame (mag lo/hi, phase 4 bytes)
//   IDX_W    : width of the byte index counter
package cordic_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TX   = 2'd1,
    ST_RX   = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  localparam int TX_BYTES = 4;
  localparam int RX_BYTES = 6;
  localparam int IDX_W    = 3;

  localparam logic [IDX_W-1:0] TX_LAST = IDX_W'(TX_BYTES - 1);
  localparam logic [IDX_W-1:0] RX_LAST = IDX_W'(RX_BYTES - 1);

endpackage

// File: rtl/cordic_link_watchdog.sv
// Link watchdog: counts idle cycles while enabled and flags expiry when the
// count reaches TIMEOUT-1 without a clear on that cycle.
//   clk, rst_n : clock, async active-low reset
//   i_en       : count enable (link phase active)
//   i_clr      : restart count (a link handshake happened this cycle)
//   o_expire   : combinational, high on the cycle the abort should take effect
module cordic_link_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // A handshake on the final cycle rescues the transfer.
  assign o_expire = i_en && !i_clr && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (!i_en || i_clr || o_expire)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/cordic_host_link.sv
// Host-side end of the CORDIC byte link. Takes one (x,y) request, sends it
// as 4 little-endian bytes on the tx channel, collects 6 result bytes
// (mag[15:0], phase[31:0], little-endian) from the rx channel and presents
// them on the response port. A watchdog aborts a stalled frame.
//   clk, rst_n                        : clock, async active-low reset
//   req_valid/req_ready/req_x/req_y   : request port
//   rsp_valid/rsp_ready/rsp_mag/phase : response port
//   link_tx_data/valid/ready          : bytes toward the tile
//   link_rx_data/valid/ready          : bytes from the tile
//   busy                              : not idle
//   timeout_err                       : one-cycle pulse on watchdog abort
module cordic_host_link
  import cordic_link_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int PHASE_W = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_x,
  input  logic [WIDTH-1:0]   req_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_mag,
  output logic [PHASE_W-1:0] rsp_phase,
  output logic [7:0]         link_tx_data,
  output logic               link_tx_valid,
  input  logic               link_tx_ready,
  input  logic [7:0]         link_rx_data,
  input  logic               link_rx_valid,
  output logic               link_rx_ready,
  output logic               busy,
  output logic               timeout_err
);

  localparam int TXW = 2 * WIDTH;
  localparam int RXW = WIDTH + PHASE_W;

  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [TXW-1:0]       r_tx_sr;   // bytes still to send, next-after-current at [15:8]
  logic [RXW-1:0]       r_rx_asm;  // shifts in from the top, first byte ends at [7:0]
  logic                 r_req_ready;
  logic                 r_rsp_valid;
  logic [WIDTH-1:0]     r_rsp_mag;
  logic [PHASE_W-1:0]   r_rsp_phase;
  logic [7:0]           r_tx_data;
  logic                 r_tx_valid;
  logic                 r_rx_ready;
  logic                 r_busy;
  logic                 r_timeout_err;

  logic                 w_tx_hs;
  logic                 w_rx_hs;
  logic                 w_wd_en;
  logic                 w_wd_expire;
  logic [RXW-1:0]       w_rx_next;

  assign w_tx_hs   = (r_state == ST_TX) && r_tx_valid && link_tx_ready;
  assign w_rx_hs   = (r_state == ST_RX) && r_rx_ready && link_rx_valid;
  assign w_wd_en   = (r_state == ST_TX) || (r_state == ST_RX);
  assign w_rx_next = {link_rx_data, r_rx_asm[RXW-1:8]};

  // Every TX->RX move coincides with a handshake and IDLE disables the
  // counter, so clearing on handshakes also covers state changes.
  cordic_link_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_wd_en),
    .i_clr    (w_tx_hs || w_rx_hs),
    .o_expire (w_wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_tx_sr       <= '0;
      r_rx_asm      <= '0;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_mag     <= '0;
      r_rsp_phase   <= '0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_rx_ready    <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      if (w_wd_expire) begin
        // Abort: the far end may be left mid-frame.
        r_state       <= ST_IDLE;
        r_idx         <= '0;
        r_tx_valid    <= 1'b0;
        r_rx_ready    <= 1'b0;
        r_req_ready   <= 1'b1;
        r_busy        <= 1'b0;
        r_timeout_err <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (req_valid && r_req_ready) begin
              r_tx_sr     <= {req_y, req_x};
              r_tx_data   <= req_x[7:0];
              r_tx_valid  <= 1'b1;
              r_req_ready <= 1'b0;
              r_busy      <= 1'b1;
              r_idx       <= '0;
              r_state     <= ST_TX;
            end
          end
          ST_TX: begin
            if (w_tx_hs) begin
              if (r_idx == TX_LAST) begin
                r_tx_valid <= 1'b0;
                r_rx_ready <= 1'b1;
                r_idx      <= '0;
                r_state    <= ST_RX;
              end else begin
                r_tx_sr   <= r_tx_sr >> 8;
                r_tx_data <= r_tx_sr[15:8];
                r_idx     <= r_idx + 3'd1;
              end
            end
          end
          ST_RX: begin
            if (w_rx_hs) begin
              r_rx_asm <= w_rx_next;
              if (r_idx == RX_LAST) begin
                r_rx_ready  <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_rsp_mag   <= w_rx_next[WIDTH-1:0];
                r_rsp_phase <= w_rx_next[RXW-1:WIDTH];
                r_idx       <= '0;
                r_state     <= ST_RSP;
              end else begin
                r_idx <= r_idx + 3'd1;
              end
            end
          end
          ST_RSP: begin
            if (rsp_ready) begin
              r_rsp_valid <= 1'b0;
              r_req_ready <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_mag       = r_rsp_mag;
  assign rsp_phase     = r_rsp_phase;
  assign link_tx_data  = r_tx_data;
  assign link_tx_valid = r_tx_valid;
  assign link_rx_ready = r_rx_ready;
  assign busy          = r_busy;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_cordic_host_link.sv
module tb_cordic_host_link;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_x = '0;
  logic [15:0] req_y = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_mag;
  logic [31:0] rsp_phase;
  logic [7:0]  link_tx_data;
  logic        link_tx_valid;
  logic        link_tx_ready = 1'b0;
  logic [7:0]  link_rx_data = '0;
  logic        link_rx_valid = 1'b0;
  logic        link_rx_ready;
  logic        busy;
  logic        timeout_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cordic_host_link #(.WIDTH(16), .PHASE_W(32), .TIMEOUT(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_x         (req_x),
    .req_y         (req_y),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_mag       (rsp_mag),
    .rsp_phase     (rsp_phase),
    .link_tx_data  (link_tx_data),
    .link_tx_valid (link_tx_valid),
    .link_tx_ready (link_tx_ready),
    .link_rx_data  (link_rx_data),
    .link_rx_valid (link_rx_valid),
    .link_rx_ready (link_rx_ready),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_tx_valid"}, link_tx_valid, 0);
    chk({tag, "_rx_ready"}, link_rx_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_tx_data"}, link_tx_data, 0);
    chk({tag, "_rsp_mag"}, rsp_mag, 0);
    chk({tag, "_rsp_phase"}, rsp_phase, 0);
  endtask

  // Present a request with the tile always ready; leaves the first byte on the link.
  task automatic send_req(input logic [15:0] x, input logic [15:0] y);
    req_x = x; req_y = y; req_valid = 1'b1; link_tx_ready = 1'b1;
    chk("idle_req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("tx_valid_first", link_tx_valid, 1);
    chk("tx_busy", busy, 1);
    chk("tx_req_ready", req_ready, 0);
  endtask

  task automatic tx_all(input logic [31:0] exp);
    for (int i = 0; i < 4; i++) begin
      chk("tx_byte", link_tx_data, exp[8*i +: 8]);
      step();
    end
    chk("tx_done_valid", link_tx_valid, 0);
    chk("rx_ready_on", link_rx_ready, 1);
  endtask

  task automatic rx_frame(input logic [47:0] v);
    for (int i = 0; i < 6; i++) begin
      link_rx_data = v[8*i +: 8];
      link_rx_valid = 1'b1;
      chk("rx_ready_hold", link_rx_ready, 1);
      chk("rx_no_rsp_yet", rsp_valid, 0);
      step();
    end
    link_rx_valid = 1'b0;
    chk("rsp_valid_set", rsp_valid, 1);
    chk("rx_ready_off", link_rx_ready, 0);
    chk("rsp_mag", rsp_mag, v[15:0]);
    chk("rsp_phase", rsp_phase, v[47:16]);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_taken_valid", rsp_valid, 0);
    chk("rsp_taken_req_ready", req_ready, 1);
    chk("rsp_taken_busy", busy, 0);
  endtask

  initial begin
    logic [6:0]  pat;
    logic [31:0] bytes3;
    int          idx;

    // 1: reset state
    #12;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    chk_reset_vals("post_reset");

    // 2: basic transaction
    send_req(16'h0300, 16'h0400);
    tx_all(32'h0400_0300);
    rx_frame(48'h1234_5678_0005);
    chk("t2_mag", rsp_mag, 16'h0005);
    chk("t2_phase", rsp_phase, 32'h1234_5678);
    take_rsp();

    // 3: tx backpressure 1,0,0,1,0,1,1 (bit 0 first)
    pat = 7'b1101001;
    bytes3 = 32'h4433_2211;
    idx = 0;
    send_req(16'h2211, 16'h4433);
    for (int i = 0; i < 7; i++) begin
      link_tx_ready = pat[i];
      chk("t3_tx_valid", link_tx_valid, 1);
      chk("t3_tx_byte", link_tx_data, bytes3[8*idx +: 8]);
      step();
      if (pat[i]) idx++;
    end
    link_tx_ready = 1'b0;
    chk("t3_tx_done", link_tx_valid, 0);
    chk("t3_rx_ready", link_rx_ready, 1);
    rx_frame(48'hDEAD_C0DE_BEEF);
    take_rsp();

    // 4: response held under rsp_ready=0; requests ignored meanwhile
    send_req(16'h1234, 16'h5678);
    tx_all(32'h5678_1234);
    rx_frame(48'hA5A5_0F0F_7FFF);
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_hold_mag", rsp_mag, 16'h7FFF);
      chk("t4_hold_phase", rsp_phase, 32'hA5A5_0F0F);
      chk("t4_hold_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    take_rsp();
    step();
    chk("t4_idle_stays", busy, 0);

    // 5: watchdog expiry in RX (TIMEOUT=16)
    send_req(16'h0001, 16'h0002);
    tx_all(32'h0002_0001);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("t5_still_rx", link_rx_ready, 1);
      chk("t5_no_pulse", timeout_err, 0);
    end
    step();
    chk("t5_pulse", timeout_err, 1);
    chk("t5_rx_dropped", link_rx_ready, 0);
    chk("t5_idle_busy", busy, 0);
    chk("t5_req_ready", req_ready, 1);
    chk("t5_no_rsp", rsp_valid, 0);
    step();
    chk("t5_pulse_once", timeout_err, 0);
    chk("t5_no_rsp_after", rsp_valid, 0);
    send_req(16'hFFFF, 16'h8000);
    tx_all(32'h8000_FFFF);
    rx_frame(48'h0000_0001_0100);
    take_rsp();

    // 6: reset after two rx bytes
    send_req(16'h0A0B, 16'h0C0D);
    tx_all(32'h0C0D_0A0B);
    link_rx_valid = 1'b1;
    link_rx_data = 8'h11; step();
    link_rx_data = 8'h22; step();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    link_rx_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk_reset_vals("t6_after");
    send_req(16'h0A0B, 16'h0C0D);
    tx_all(32'h0C0D_0A0B);
    rx_frame(48'h8765_4321_3344);
    take_rsp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
